// File: rtl/sram_controller.sv
// ============================================================================
// sram_controller : bus-side single-word access to an async 32-bit SRAM
// Revision: 1.0
// ============================================================================
`default_nettype none

module sram_controller #(
  parameter int ADDR_WIDTH  = 20,
  parameter int READ_WAIT   = 2,
  parameter int WRITE_PULSE = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [23:0]           ram_addr,
  input  logic [31:0]           write_data_to_ram,
  input  logic [3:0]            ram_byte_enable,
  input  logic                  ram_read_enable,
  input  logic                  ram_write_enable,
  output logic [31:0]           read_data_from_ram,
  output logic                  ram_stall,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  inout  wire  [31:0]           sram_data,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic [3:0]            sram_be_n
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD       = 3'd1;
  localparam logic [2:0] S_WR_SETUP = 3'd2;
  localparam logic [2:0] S_WR_PULSE = 3'd3;
  localparam logic [2:0] S_WR_HOLD  = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  localparam int              CNT_W   = 8;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_PULSE - 1);

  logic [2:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  ce_n_q, ce_n_d;
  logic                  oe_n_q, oe_n_d;
  logic                  we_n_q, we_n_d;
  logic [3:0]            be_n_q, be_n_d;
  logic                  drive_q, drive_d;

  // Byte-lane and out-of-range address bits are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ram_addr[23:ADDR_WIDTH+2], ram_addr[1:0]};

  // State, request latches and all SRAM pins are registered; reset is immediate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      be_n_q  <= 4'hF;
      drive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      be_n_q  <= be_n_d;
      drive_q <= drive_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (ram_write_enable) begin
          addr_d  = ram_addr[ADDR_WIDTH+1:2];
          wdata_d = write_data_to_ram;
          be_d    = ram_byte_enable;
          state_d = S_WR_SETUP;
        end else if (ram_read_enable) begin
          addr_d  = ram_addr[ADDR_WIDTH+1:2];
          cnt_d   = RD_LOAD;
          state_d = S_RD;
        end
      end
      S_RD: begin
        if (cnt_q == '0) begin
          rdata_d = sram_data;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WR_SETUP: begin
        cnt_d   = WR_LOAD;
        state_d = S_WR_PULSE;
      end
      S_WR_PULSE: begin
        if (cnt_q == '0) begin
          state_d = S_WR_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WR_HOLD: state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Pin values are decoded from the next state so they are valid for the
  // whole cycle the FSM spends in that state.
  always_comb begin
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    be_n_d  = 4'hF;
    drive_d = 1'b0;
    case (state_d)
      S_RD: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
        be_n_d = 4'b0000;
      end
      S_WR_SETUP, S_WR_HOLD: begin
        ce_n_d  = 1'b0;
        be_n_d  = ~be_d;
        drive_d = 1'b1;
      end
      S_WR_PULSE: begin
        ce_n_d  = 1'b0;
        we_n_d  = 1'b0;
        be_n_d  = ~be_d;
        drive_d = 1'b1;
      end
      default: begin
        ce_n_d = 1'b1;
      end
    endcase
  end

  assign ram_stall          = (ram_read_enable | ram_write_enable) & (state_q != S_DONE);
  assign read_data_from_ram = rdata_q;
  assign sram_addr          = addr_q;
  assign sram_ce_n          = ce_n_q;
  assign sram_oe_n          = oe_n_q;
  assign sram_we_n          = we_n_q;
  assign sram_be_n          = be_n_q;
  assign sram_data          = drive_q ? wdata_q : 32'hzzzz_zzzz;

endmodule

`default_nettype wire

// File: tb/tb_sram_controller.sv
// ============================================================================
// tb_sram_controller : directed self-checking bench with a behavioural SRAM
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] ram_addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        re;
  logic        we;
  logic [31:0] read_data;
  logic        ram_stall;
  logic [19:0] sram_addr;
  wire  [31:0] sram_data;
  logic        ce_n;
  logic        oe_n;
  logic        we_n;
  logic [3:0]  be_n;

  logic [31:0] mem [0:15];
  logic        probe_en;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  sram_controller #(
    .ADDR_WIDTH (20),
    .READ_WAIT  (2),
    .WRITE_PULSE(2)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ram_addr          (ram_addr),
    .write_data_to_ram (wdata),
    .ram_byte_enable   (be),
    .ram_read_enable   (re),
    .ram_write_enable  (we),
    .read_data_from_ram(read_data),
    .ram_stall         (ram_stall),
    .sram_addr         (sram_addr),
    .sram_data         (sram_data),
    .sram_ce_n         (ce_n),
    .sram_oe_n         (oe_n),
    .sram_we_n         (we_n),
    .sram_be_n         (be_n)
  );

  // SRAM model drives on a read; otherwise a probe may pull the bus to 0 so
  // that any stray controller drive becomes visible as a non-zero value.
  wire model_drv = !ce_n && !oe_n && we_n;
  assign sram_data = model_drv ? mem[sram_addr[3:0]] : (probe_en ? 32'h0 : 32'hzzzz_zzzz);

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[2] <= 32'hAABB_CCDD;
      mem[4] <= 32'hDEAD_BEEF;
      mem[8] <= 32'h0BAD_F00D;
    end else if (!ce_n && !we_n) begin
      for (int b = 0; b < 4; b++)
        if (!be_n[b]) mem[sram_addr[3:0]][8*b +: 8] <= sram_data[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; re = 1'b0; we = 1'b0;
    ram_addr = 24'h0; wdata = 32'h0; be = 4'h0; probe_en = 1'b1;
    step(); step();
    chk("rst_rdata", read_data, 32'h0);
    chk("rst_addr",  32'(sram_addr), 32'h0);
    chk("rst_ce_n",  32'(ce_n), 32'h1);
    chk("rst_oe_n",  32'(oe_n), 32'h1);
    chk("rst_we_n",  32'(we_n), 32'h1);
    chk("rst_be_n",  32'(be_n), 32'hF);
    chk("rst_bus_z", sram_data, 32'h0);
    chk("rst_stall", 32'(ram_stall), 32'h0);
    rst_n = 1'b1;
    step();

    // Read of byte address 0x10 -> word 4
    probe_en = 1'b0; ram_addr = 24'h000010; re = 1'b1; #1;
    chk("rd_stall_t0", 32'(ram_stall), 32'h1);
    step();
    chk("rd_addr",     32'(sram_addr), 32'h4);
    chk("rd_ce_t1",    32'(ce_n), 32'h0);
    chk("rd_oe_t1",    32'(oe_n), 32'h0);
    chk("rd_stall_t1", 32'(ram_stall), 32'h1);
    step();
    chk("rd_oe_t2",    32'(oe_n), 32'h0);
    chk("rd_stall_t2", 32'(ram_stall), 32'h1);
    step();
    chk("rd_stall_done", 32'(ram_stall), 32'h0);
    chk("rd_oe_done",    32'(oe_n), 32'h1);
    chk("rd_ce_done",    32'(ce_n), 32'h1);
    chk("rd_data_done",  read_data, 32'hDEAD_BEEF);
    re = 1'b0; probe_en = 1'b1;
    step();
    chk("rd_idle_bus_z", sram_data, 32'h0);
    chk("rd_data_held",  read_data, 32'hDEAD_BEEF);

    // Write 0x12345678 lanes 1:0 to byte address 0x8 -> word 2
    probe_en = 1'b0; ram_addr = 24'h000008; wdata = 32'h1234_5678; be = 4'b0011; we = 1'b1; #1;
    chk("wr_stall_t0", 32'(ram_stall), 32'h1);
    step();
    chk("wr_addr",      32'(sram_addr), 32'h2);
    chk("wr_be_n",      32'(be_n), 32'hC);
    chk("wr_setup_we",  32'(we_n), 32'h1);
    chk("wr_setup_ce",  32'(ce_n), 32'h0);
    chk("wr_setup_oe",  32'(oe_n), 32'h1);
    chk("wr_setup_bus", sram_data, 32'h1234_5678);
    wdata = 32'hFFFF_FFFF; ram_addr = 24'h00003C; be = 4'hF;
    step();
    chk("wr_pulse1_we",   32'(we_n), 32'h0);
    chk("wr_pulse1_bus",  sram_data, 32'h1234_5678);
    chk("wr_pulse1_addr", 32'(sram_addr), 32'h2);
    chk("wr_pulse1_be_n", 32'(be_n), 32'hC);
    step();
    chk("wr_pulse2_we",    32'(we_n), 32'h0);
    chk("wr_pulse2_stall", 32'(ram_stall), 32'h1);
    step();
    chk("wr_hold_we",    32'(we_n), 32'h1);
    chk("wr_hold_ce",    32'(ce_n), 32'h0);
    chk("wr_hold_bus",   sram_data, 32'h1234_5678);
    chk("wr_hold_stall", 32'(ram_stall), 32'h1);
    step();
    chk("wr_done_stall", 32'(ram_stall), 32'h0);
    chk("wr_done_ce",    32'(ce_n), 32'h1);
    chk("wr_mem_word2",  mem[2], 32'hAABB_5678);
    chk("wr_rdata_kept", read_data, 32'hDEAD_BEEF);
    we = 1'b0; probe_en = 1'b1; #1;
    chk("wr_done_bus_z", sram_data, 32'h0);
    step();
    chk("wr_idle_bus_z", sram_data, 32'h0);

    // Read back the word just written
    probe_en = 1'b0; ram_addr = 24'h000008; re = 1'b1;
    step();
    chk("rb_oe", 32'(oe_n), 32'h0);
    step();
    step();
    chk("rb_data",  read_data, 32'hAABB_5678);
    chk("rb_stall", 32'(ram_stall), 32'h0);
    re = 1'b0;
    step();

    // Both enables high: the write wins
    ram_addr = 24'h000020; wdata = 32'h1122_3344; be = 4'hF; we = 1'b1; re = 1'b1; #1;
    chk("both_stall_t0", 32'(ram_stall), 32'h1);
    step();
    chk("both_setup_oe", 32'(oe_n), 32'h1);
    chk("both_addr",     32'(sram_addr), 32'h8);
    step();
    chk("both_pulse_we", 32'(we_n), 32'h0);
    chk("both_pulse_oe", 32'(oe_n), 32'h1);
    step();
    chk("both_pulse2_we", 32'(we_n), 32'h0);
    step();
    chk("both_hold_we", 32'(we_n), 32'h1);
    step();
    chk("both_done_stall", 32'(ram_stall), 32'h0);
    chk("both_no_capture", read_data, 32'hAABB_5678);
    chk("both_mem_word8",  mem[8], 32'h1122_3344);
    we = 1'b0; re = 1'b0;
    step();

    // Read enable dropped after one stall cycle
    ram_addr = 24'h000010; re = 1'b1; #1;
    chk("drop_stall_t0", 32'(ram_stall), 32'h1);
    step();
    re = 1'b0; #1;
    chk("drop_stall_low", 32'(ram_stall), 32'h0);
    chk("drop_oe_t1",     32'(oe_n), 32'h0);
    step();
    chk("drop_oe_t2", 32'(oe_n), 32'h0);
    chk("drop_ce_t2", 32'(ce_n), 32'h0);
    step();
    chk("drop_done_ce", 32'(ce_n), 32'h1);
    chk("drop_done_oe", 32'(oe_n), 32'h1);
    step();
    ram_addr = 24'h000020; re = 1'b1; #1;
    chk("next_stall_t0", 32'(ram_stall), 32'h1);
    step();
    chk("next_addr", 32'(sram_addr), 32'h8);
    step();
    chk("next_stall_t2", 32'(ram_stall), 32'h1);
    step();
    chk("next_data",  read_data, 32'h1122_3344);
    chk("next_stall", 32'(ram_stall), 32'h0);
    re = 1'b0;
    step();

    // Reset asserted during the write pulse
    ram_addr = 24'h000004; wdata = 32'hCAFE_BABE; be = 4'hF; we = 1'b1;
    step();
    step();
    chk("mid_pulse_we", 32'(we_n), 32'h0);
    probe_en = 1'b1; rst_n = 1'b0; #1;
    chk("mid_rst_we_n",  32'(we_n), 32'h1);
    chk("mid_rst_ce_n",  32'(ce_n), 32'h1);
    chk("mid_rst_be_n",  32'(be_n), 32'hF);
    chk("mid_rst_bus_z", sram_data, 32'h0);
    chk("mid_rst_rdata", read_data, 32'h0);
    chk("mid_rst_addr",  32'(sram_addr), 32'h0);
    we = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    probe_en = 1'b0; ram_addr = 24'h000010; re = 1'b1;
    step();
    chk("post_rst_oe",   32'(oe_n), 32'h0);
    chk("post_rst_addr", 32'(sram_addr), 32'h4);
    step();
    step();
    chk("post_rst_data", read_data, 32'hDEAD_BEEF);
    re = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
